cpu_ctrl_fsm: RTL and testbench

Instruction sequencer and execution controller for the 8-bit CPU. Each instruction goes through fetch, decode and execute. The block owns the program counter (PC), instruction register, accumulator and flags. It drives the address of the combinational instruction ROM and executes the 16-bit instruction word the ROM returns. Results go out through a registered output port with a one-cycle valid strobe.

---
 rtl/cpu_ctrl_fsm_if.sv | 28 ++
 rtl/cpu_ctrl_fsm.sv | 166 ++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_fsm_if.sv
// Bus bundle between the CPU controller and its environment.
// The bundle carries the run enable, the instruction ROM port and the architectural outputs.
interface cpu_ctrl_fsm_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned INSN_W = 16;

  logic              run;
  logic [ADDR_W-1:0] rom_addr;
  logic [INSN_W-1:0] rom_data;
  logic [DATA_W-1:0] acc;
  logic              zero;
  logic              carry;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic              illegal;

  modport master (
    input  run, rom_data,
    output rom_addr, acc, zero, carry, out_data, out_valid, halted, illegal
  );

  modport slave (
    output run, rom_data,
    input  rom_addr, acc, zero, carry, out_data, out_valid, halted, illegal
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// The module owns the PC, the instruction register, the accumulator, the flags and the registered OUT port.
module cpu_ctrl_fsm (
  input  logic          clk,
  input  logic          rst_n,
  cpu_ctrl_fsm_if.master bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned INSN_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT} state_t;
  typedef enum logic [2:0] {CLS_NOP, CLS_ALU, CLS_JUMP, CLS_OUT, CLS_HALT} cls_t;

  state_t             state_q, state_d;
  cls_t               cls_q, cls_d;
  logic               bad_q, bad_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [INSN_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;

  logic [3:0]         opcode;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W:0]    sum;
  logic [DATA_W-1:0]  diff;

  assign opcode = ir_q[15:12];
  assign imm    = ir_q[7:0];
  assign sum    = {1'b0, acc_q} + {1'b0, imm};
  assign diff   = acc_q - imm;

  // State and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      cls_q       <= CLS_NOP;
      bad_q       <= 1'b0;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      bad_q       <= bad_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    bad_d       = bad_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    illegal_d   = illegal_q;

    case (state_q)
      ST_FETCH: begin
        if (bus.run) begin
          ir_d    = bus.rom_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        bad_d   = 1'b0;
        state_d = ST_EXEC;
        case (opcode)
          OP_NOP:                  cls_d = CLS_NOP;
          OP_LOAD, OP_ADD, OP_SUB: cls_d = CLS_ALU;
          OP_JMP, OP_JZ:           cls_d = CLS_JUMP;
          OP_OUT:                  cls_d = CLS_OUT;
          OP_HALT:                 cls_d = CLS_HALT;
          default: begin
            cls_d = CLS_NOP;
            bad_d = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + 8'd1;
        case (cls_q)
          CLS_ALU: begin
            case (opcode)
              OP_LOAD: begin
                acc_d   = imm;
                carry_d = 1'b0;
                zero_d  = (imm == '0);
              end
              OP_ADD: begin
                acc_d   = sum[DATA_W-1:0];
                carry_d = sum[DATA_W];
                zero_d  = (sum[DATA_W-1:0] == '0);
              end
              default: begin
                acc_d   = diff;
                carry_d = (imm > acc_q);
                zero_d  = (diff == '0);
              end
            endcase
          end
          CLS_JUMP: begin
            if (opcode == OP_JMP || zero_q) pc_d = imm;
          end
          CLS_OUT: begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
          end
          CLS_HALT: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            if (bad_q) illegal_d = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign bus.rom_addr  = pc_q;
  assign bus.acc       = acc_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.halted    = halted_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm.
// An instruction-level reference model fills the expected-state and expected-OUT queues, and a cycle monitor compares the DUT against them.
module tb_cpu_ctrl_fsm;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [15:0] rom [256];

  cpu_ctrl_fsm_if bus ();

  cpu_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] acc;
    logic       z;
    logic       c;
    logic       ill;
    logic       hlt;
  } snap_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } out_t;

  snap_t snap_q[$];
  out_t  out_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // ISA-level reference: one entry per instruction slot (3 cycles each, run held high in FETCH)
  task automatic model_run(input int n);
    logic [7:0] pc, acc, imm, nxt;
    logic       z, c, ill, h;
    logic [15:0] iw;
    logic [8:0]  s9;
    pc = 8'h00; acc = 8'h00; z = 1'b0; c = 1'b0; ill = 1'b0; h = 1'b0;
    for (int k = 0; k < n; k++) begin
      snap_q.push_back(snap_t'{pc, acc, z, c, ill, h});
      if (!h) begin
        iw  = rom[pc];
        imm = iw[7:0];
        nxt = pc + 8'd1;
        case (iw[15:12])
          4'h0: ;
          4'h1: begin acc = imm; c = 1'b0; z = (acc == 8'h00); end
          4'h2: begin s9 = {1'b0, acc} + {1'b0, imm}; acc = s9[7:0]; c = s9[8]; z = (acc == 8'h00); end
          4'h3: begin c = (imm > acc); acc = acc - imm; z = (acc == 8'h00); end
          4'h6: nxt = imm;
          4'h7: if (z) nxt = imm;
          4'h8: out_q.push_back(out_t'{acc, 3 * k + 3});
          4'hF: begin h = 1'b1; nxt = pc; end
          default: ill = 1'b1;
        endcase
        pc = nxt;
      end
    end
    snap_q.push_back(snap_t'{pc, acc, z, c, ill, h});
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_pc",        16'(bus.rom_addr),  16'h0000);
    check_eq("rst_acc",       16'(bus.acc),       16'h0000);
    check_eq("rst_zero",      16'(bus.zero),      16'h0000);
    check_eq("rst_carry",     16'(bus.carry),     16'h0000);
    check_eq("rst_out_data",  16'(bus.out_data),  16'h0000);
    check_eq("rst_out_valid", 16'(bus.out_valid), 16'h0000);
    check_eq("rst_halted",    16'(bus.halted),    16'h0000);
    check_eq("rst_illegal",   16'(bus.illegal),   16'h0000);
    rst_n = 1'b1;
  endtask

  // Runs n instruction slots after an optional FETCH stall; run toggles randomly outside FETCH
  task automatic run_prog(input int n, input int stall);
    snap_t s;
    out_t  o;
    model_run(n);
    for (int i = 0; i < stall; i++) begin
      bus.run = 1'b0;
      check_eq("stall_pc",    16'(bus.rom_addr),  16'h0000);
      check_eq("stall_valid", 16'(bus.out_valid), 16'h0000);
      @(negedge clk);
    end
    for (int cyc = 0; cyc <= 3 * n; cyc++) begin
      if (cyc % 3 == 0) begin
        s = snap_q.pop_front();
        check_eq("pc",      16'(bus.rom_addr), 16'(s.pc));
        check_eq("acc",     16'(bus.acc),      16'(s.acc));
        check_eq("zero",    16'(bus.zero),     16'(s.z));
        check_eq("carry",   16'(bus.carry),    16'(s.c));
        check_eq("illegal", 16'(bus.illegal),  16'(s.ill));
        check_eq("halted",  16'(bus.halted),   16'(s.hlt));
      end
      if (bus.out_valid) begin
        if (out_q.size() == 0) begin
          check_eq("out_extra", 16'(1), 16'(0));
        end else begin
          o = out_q.pop_front();
          check_eq("out_data", 16'(bus.out_data), 16'(o.data));
          check_eq("out_cyc",  16'(cyc),          16'(o.cyc));
        end
      end
      if (cyc == 3 * n) break;
      bus.run = (cyc % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check_eq("out_left", 16'(out_q.size()), 16'h0000);
    out_q.delete();
    snap_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus.run  = 1'b0;

    // Sample loop program: OUT values 1,2,2,3,3,4,...
    clear_rom();
    rom[0] = 16'h1001; rom[1] = 16'h8000; rom[2] = 16'h2001;
    rom[3] = 16'h8000; rom[4] = 16'h6001;
    do_reset();
    run_prog(20, 0);

    // Flags, wrap, both JZ paths, illegal opcodes, PC wrap and HALT, after a 10-cycle stall
    clear_rom();
    rom[8'h00] = 16'h7020; rom[8'h01] = 16'h6030;
    rom[8'h30] = 16'h10FF; rom[8'h31] = 16'h2001; rom[8'h32] = 16'h3001;
    rom[8'h33] = 16'h1000; rom[8'h34] = 16'h7010;
    rom[8'h10] = 16'h1005; rom[8'h11] = 16'h7040; rom[8'h12] = 16'h4000;
    rom[8'h13] = 16'h8000; rom[8'h14] = 16'h5123; rom[8'h15] = 16'h1000;
    rom[8'h16] = 16'h60FE;
    rom[8'h20] = 16'hF000;
    do_reset();
    run_prog(24, 10);
    for (int i = 0; i < 20; i++) begin
      bus.run = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("halt_pc",  16'(bus.rom_addr), 16'h0020);
      check_eq("halt_flg", 16'(bus.halted),   16'h0001);
    end

    // Asynchronous reset during the EXEC cycle of an OUT
    clear_rom();
    rom[0] = 16'h105A; rom[1] = 16'h8000;
    do_reset();
    bus.run = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("pre_acc", 16'(bus.acc),      16'h005A);
    check_eq("pre_pc",  16'(bus.rom_addr), 16'h0001);
    rst_n = 1'b0;
    #1;
    check_eq("arst_acc",   16'(bus.acc),       16'h0000);
    check_eq("arst_pc",    16'(bus.rom_addr),  16'h0000);
    check_eq("arst_valid", 16'(bus.out_valid), 16'h0000);
    @(posedge clk);
    #1;
    check_eq("arst_no_pulse", 16'(bus.out_valid), 16'h0000);
    check_eq("arst_out_data", 16'(bus.out_data),  16'h0000);
    @(negedge clk);
    do_reset();
    run_prog(4, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
